// File: rtl/lzss_bitpack.sv
// lzss_bitpack: packs 9-bit literal and 11-bit match codes MSB-first into
// 32-bit words, with a zero-padded flush word once the encoder finishes.
module lzss_bitpack (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] cw_in,
    input  logic        cw_valid,
    input  logic        enc_finish,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] total_bits,
    output logic [11:0] word_cnt,
    output logic        overflow,
    output logic        done
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] acc, acc_nx, acc_sh, code_al;
    logic [6:0]  fill, fill_nx, eff;
    logic [7:0]  room;
    logic [3:0]  len;
    logic [31:0] pad_mask;
    logic [31:0] out_word_nx;
    logic        out_valid_nx;
    logic [15:0] total_bits_nx;
    logic [11:0] word_cnt_nx;
    logic        overflow_nx;
    logic        out_free, accept, emit, pad_emit, append, fits;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= state_nx;
    end

    // Next-state logic: flush begins on finish, ends once nothing is left or pending
    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:   if (enc_finish) state_nx = S_FLUSH;
            S_FLUSH: if (fill == 7'd0 && !out_valid) state_nx = S_DONE;
            default: state_nx = S_DONE;
        endcase
    end

    // Datapath next values: emit (full or padded) and append resolved in one cycle
    always_comb begin
        out_free = !out_valid | out_ready;
        accept   = out_valid & out_ready;
        emit     = (state == S_RUN || state == S_FLUSH) && fill >= 7'd32 && out_free;
        pad_emit = (state == S_FLUSH) && fill != 7'd0 && fill < 7'd32 && out_free;
        append   = (state == S_RUN) && cw_valid;

        len      = cw_in[10] ? 4'd11 : 4'd9;
        code_al  = cw_in[10] ? {cw_in, 53'b0} : {cw_in[10:2], 55'b0};
        eff      = emit ? fill - 7'd32 : fill;
        acc_sh   = emit ? {acc[31:0], 32'b0} : acc;
        room     = {1'b0, eff} + {4'b0, len};
        fits     = room <= 8'd64;
        pad_mask = ~(32'hFFFF_FFFF >> fill[4:0]);

        acc_nx        = acc_sh;
        fill_nx       = eff;
        out_word_nx   = out_word;
        out_valid_nx  = out_valid & !accept;
        total_bits_nx = total_bits;
        word_cnt_nx   = word_cnt + {11'b0, accept};
        overflow_nx   = overflow;

        if (emit) begin
            out_word_nx  = acc[63:32];
            out_valid_nx = 1'b1;
        end else if (pad_emit) begin
            out_word_nx  = acc[63:32] & pad_mask;
            out_valid_nx = 1'b1;
            acc_nx       = '0;
            fill_nx      = '0;
        end

        if (append) begin
            if (fits) begin
                acc_nx        = acc_sh | (code_al >> eff);
                fill_nx       = room[6:0];
                total_bits_nx = total_bits + {12'b0, len};
            end else begin
                overflow_nx = 1'b1;
            end
        end

        done = (state == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            fill       <= '0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            total_bits <= '0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            acc        <= acc_nx;
            fill       <= fill_nx;
            out_word   <= out_word_nx;
            out_valid  <= out_valid_nx;
            total_bits <= total_bits_nx;
            word_cnt   <= word_cnt_nx;
            overflow   <= overflow_nx;
        end
    end

endmodule

// File: tb/tb_lzss_bitpack.sv
// Directed self-checking bench for lzss_bitpack.
module tb_lzss_bitpack;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] cw_in;
    logic        cw_valid;
    logic        enc_finish;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] total_bits;
    logic [11:0] word_cnt;
    logic        overflow;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rx[$];

    logic [255:0] mstream;
    int           mbits;

    lzss_bitpack dut (
        .clk(clk), .reset(reset), .cw_in(cw_in), .cw_valid(cw_valid),
        .enc_finish(enc_finish), .out_word(out_word), .out_valid(out_valid),
        .out_ready(out_ready), .total_bits(total_bits), .word_cnt(word_cnt),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    // Record every word the consumer accepts at the coming edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) rx.push_back(out_word);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cw_valid = 1'b0;
        enc_finish = 1'b0;
        tick();
        tick();
        rx.delete();
        reset = 1'b0;
    endtask

    task automatic send(input logic [10:0] cw);
        cw_in = cw;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (done) break;
            tick();
        end
        check(tag, 64'(done), 64'd1);
    endtask

    // Reference bit stream: literal contributes cw[10:2], match all 11 bits
    task automatic model_push(input logic [10:0] cw);
        int n;
        n = cw[10] ? 11 : 9;
        for (int i = 10; i > 10 - n; i--) begin
            mstream[255 - mbits] = cw[i];
            mbits++;
        end
    endtask

    function automatic logic [31:0] model_word(input int k);
        return mstream[255 - 32*k -: 32];
    endfunction

    initial begin
        logic [10:0] t4[8];
        t4 = '{11'h2AB, 11'h155, 11'h5A5, 11'h7C3, 11'h4F0, 11'h63C, 11'h6DB, 11'h52E};
        cw_in = '0;
        cw_valid = 1'b0;
        enc_finish = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;

        // Reset state
        do_reset();
        check("rst_out_word", 64'(out_word), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_total_bits", 64'(total_bits), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Four literals then finish
        for (int i = 0; i < 4; i++) send(11'h104);
        enc_finish = 1'b1;
        wait_done("t1_done", 20);
        check("t1_nwords", 64'(rx.size()), 64'd2);
        check("t1_word0", 64'(rx[0]), 64'h2090_4824);
        check("t1_word1", 64'(rx[1]), 64'h1000_0000);
        check("t1_total_bits", 64'(total_bits), 64'd36);
        check("t1_word_cnt", 64'(word_cnt), 64'd2);
        check("t1_overflow", 64'(overflow), 64'd0);

        // Three matches: one full word, one bit left over
        do_reset();
        for (int i = 0; i < 3; i++) send(11'h7FF);
        tick();
        check("t2_out_word", 64'(out_word), 64'hFFFF_FFFF);
        check("t2_fill", 64'(dut.fill), 64'd1);
        enc_finish = 1'b1;
        wait_done("t2_done", 20);
        check("t2_nwords", 64'(rx.size()), 64'd2);
        check("t2_word1", 64'(rx[1]), 64'h8000_0000);
        check("t2_total_bits", 64'(total_bits), 64'd33);

        // Overflow under backpressure
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) send(11'h7FF);
        check("t3_held_valid", 64'(out_valid), 64'd1);
        check("t3_held_word", 64'(out_word), 64'hFFFF_FFFF);
        check("t3_fill56", 64'(dut.fill), 64'd56);
        check("t3_no_ovf_yet", 64'(overflow), 64'd0);
        send(11'h7FF);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_total_bits", 64'(total_bits), 64'd88);
        check("t3_fill_kept", 64'(dut.fill), 64'd56);
        out_ready = 1'b1;
        enc_finish = 1'b1;
        wait_done("t3_done", 30);
        check("t3_nwords", 64'(rx.size()), 64'd3);
        check("t3_word0", 64'(rx[0]), 64'hFFFF_FFFF);
        check("t3_word1", 64'(rx[1]), 64'hFFFF_FFFF);
        check("t3_word2", 64'(rx[2]), 64'hFFFF_FF00);
        check("t3_word_cnt", 64'(word_cnt), 64'd3);

        // Simultaneous emit and append across a word boundary
        do_reset();
        mstream = '0;
        mbits = 0;
        for (int i = 0; i < 6; i++) begin
            model_push(t4[i]);
            send(t4[i]);
        end
        check("t4_fill30", 64'(dut.fill), 64'd30);
        check("t4_out_idle", 64'(out_valid), 64'd0);
        check("t4_word0", 64'(rx.size() > 0 ? rx[0] : 32'hDEAD_BEEF), 64'(model_word(0)));
        model_push(t4[6]);
        send(t4[6]);
        model_push(t4[7]);
        send(t4[7]);
        check("t4_fill20", 64'(dut.fill), 64'd20);
        check("t4_emit_valid", 64'(out_valid), 64'd1);
        check("t4_word1", 64'(out_word), 64'(model_word(1)));

        // Reset mid-stream with a word pending
        reset = 1'b1;
        tick();
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_word", 64'(out_word), 64'd0);
        check("t5_word_cnt", 64'(word_cnt), 64'd0);
        check("t5_total_bits", 64'(total_bits), 64'd0);
        check("t5_fill", 64'(dut.fill), 64'd0);
        rx.delete();
        reset = 1'b0;
        send(11'h104);
        enc_finish = 1'b1;
        wait_done("t5_done", 20);
        check("t5_nwords", 64'(rx.size()), 64'd1);
        check("t5_word0", 64'(rx.size() > 0 ? rx[0] : 32'hDEAD_BEEF), 64'h2080_0000);

        // Finish with an empty accumulator
        do_reset();
        enc_finish = 1'b1;
        tick();
        check("t6_done_early", 64'(done), 64'd0);
        tick();
        check("t6_done", 64'(done), 64'd1);
        check("t6_word_cnt", 64'(word_cnt), 64'd0);
        check("t6_nwords", 64'(rx.size()), 64'd0);
        for (int i = 0; i < 3; i++) send(11'h7FF);
        check("t6_ignored_bits", 64'(total_bits), 64'd0);
        check("t6_ignored_ovf", 64'(overflow), 64'd0);
        check("t6_ignored_valid", 64'(out_valid), 64'd0);
        check("t6_done_sticky", 64'(done), 64'd1);
        enc_finish = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
